// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the RV32I control path: base opcodes (also used by
// the immediate generator), immediate-format codes, PC/writeback select
// codes, the multi-cycle state encoding and the opcode class enumeration.
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PCS_PLUS4 = 2'd0;
    localparam logic [1:0] PCS_IMM   = 2'd1;
    localparam logic [1:0] PCS_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } ctrl_state_t;

    typedef enum logic [3:0] {
        CLS_ILL    = 4'd0,
        CLS_OP     = 4'd1,
        CLS_OP_IMM = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LUI    = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } op_class_t;

    // Only register-register ALU ops and branch compares take rs2 as operand B.
    function automatic logic alu_b_is_imm(input op_class_t cls);
        return (cls != CLS_ILL) && (cls != CLS_OP) && (cls != CLS_BRANCH);
    endfunction

endpackage

// File: rtl/ctrl_opdec.sv
// ---------------------------------------------------------------------------
// ctrl_opdec
// Combinational opcode classifier, shared by the multi-cycle and
// single-cycle control units.
//   opcode   in   7  IR[6:0]
//   op_class out     instruction class (CLS_ILL when not recognised)
//   imm_sel  out  3  immediate format for the immediate generator
//   legal    out  1  opcode is one of the supported base opcodes
// ---------------------------------------------------------------------------
module ctrl_opdec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] imm_sel,
    output logic       legal
);

    always_comb begin
        op_class = CLS_ILL;
        imm_sel  = IMM_I;
        legal    = 1'b1;
        case (opcode)
            OPC_OP:     op_class = CLS_OP;
            OPC_OP_IMM: op_class = CLS_OP_IMM;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_JALR:   op_class = CLS_JALR;
            OPC_STORE: begin
                op_class = CLS_STORE;
                imm_sel  = IMM_S;
            end
            OPC_BRANCH: begin
                op_class = CLS_BRANCH;
                imm_sel  = IMM_B;
            end
            OPC_LUI: begin
                op_class = CLS_LUI;
                imm_sel  = IMM_U;
            end
            OPC_JAL: begin
                op_class = CLS_JAL;
                imm_sel  = IMM_J;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multi-cycle RV32I core. Sequences
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH over a single
// shared memory port and halts on an illegal opcode or a memory timeout.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode                IR[6:0], valid from DECODE onward
//   branch_taken          ALU compare result, valid in EXEC
//   mem_ready             memory completes the current request this cycle
//   mem_req/mem_we/mem_src  memory request, store enable, address select
//   ir_write, pc_write, reg_write  one-cycle strobes
//   pc_src, wb_sel, alu_src_b, imm_sel  datapath selects
//   illegal, bus_err      sticky halt causes
//   state                 current state (debug)
//
// Optional feature: define CTRL_PERF_CNT_EN to add cycle_cnt / instret_cnt.
//
// Strobes and selects are decoded from the registered state (and mem_ready /
// branch_taken where the transfer completes that cycle), so an asynchronous
// reset drops mem_req immediately.
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic [2:0]  imm_sel,
    output logic        illegal,
    output logic        bus_err,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
`endif
    output logic [2:0]  state
);

    ctrl_state_t     cur;
    ctrl_state_t     nxt;
    logic [TO_W-1:0] to_cnt;
    op_class_t       cls;
    logic [2:0]      dec_imm;
    logic            dec_legal;
    logic            to_limit;
    logic            raise_ill;
    logic            raise_bus;

    ctrl_opdec u_opdec (
        .opcode   (opcode),
        .op_class (cls),
        .imm_sel  (dec_imm),
        .legal    (dec_legal)
    );

    assign state = cur;

    // to_cnt holds the waiting cycles already spent, so the limit is reached
    // on the MEM_TIMEOUT-th cycle of the request; mem_ready then still wins.
    assign to_limit = (to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt       = cur;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_src   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PCS_PLUS4;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_b = 1'b0;
        imm_sel   = IMM_I;
        raise_ill = 1'b0;
        raise_bus = 1'b0;

        case (cur)
            S_IDLE: nxt = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    nxt      = S_DECODE;
                end else if (to_limit) begin
                    raise_bus = 1'b1;
                    nxt       = S_HALT;
                end
            end

            S_DECODE: begin
                if (dec_legal) begin
                    nxt = S_EXEC;
                end else begin
                    raise_ill = 1'b1;
                    nxt       = S_HALT;
                end
            end

            S_EXEC: begin
                nxt = S_FETCH;
                case (cls)
                    CLS_OP, CLS_OP_IMM:  nxt = S_WB;
                    CLS_LOAD, CLS_STORE: nxt = S_MEM;
                    CLS_BRANCH: begin
                        // Not-taken still advances the PC, by 4.
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PCS_IMM : PCS_PLUS4;
                    end
                    CLS_JAL: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                        pc_write  = 1'b1;
                        pc_src    = PCS_IMM;
                    end
                    CLS_JALR: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                        pc_write  = 1'b1;
                        pc_src    = PCS_ALU;
                    end
                    CLS_LUI: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_IMM;
                        pc_write  = 1'b1;
                    end
                    default: begin
                        // IR changed after DECODE; treat as illegal.
                        raise_ill = 1'b1;
                        nxt       = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_src = 1'b1;
                mem_we  = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_write = 1'b1;
                        nxt      = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (to_limit) begin
                    raise_bus = 1'b1;
                    nxt       = S_HALT;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls == CLS_LOAD) ? WB_MEM : WB_ALU;
                pc_write  = 1'b1;
                nxt       = S_FETCH;
            end

            default: nxt = S_HALT;
        endcase

        if (cur inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            imm_sel   = dec_imm;
            alu_src_b = alu_b_is_imm(cls);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            to_cnt  <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            cur <= nxt;
            if (mem_req && !mem_ready && (nxt == cur))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (raise_ill)
                illegal <= 1'b1;
            if (raise_bus)
                bus_err <= 1'b1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if ((cur != S_IDLE) && (cur != S_HALT))
                cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_write)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. A memory model answers requests
// after a chosen number of wait cycles; a per-instruction reference model
// derives the expected cycle count, strobe counts and select values from the
// instruction's class.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_src, ir_write, pc_write, reg_write;
    logic [1:0] pc_src, wb_sel;
    logic       alu_src_b, illegal, bus_err;
    logic [2:0] imm_sel, state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_src      (mem_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src_b    (alu_src_b),
        .imm_sel      (imm_sel),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .state        (state)
    );

    localparam logic [6:0] LEGAL_OPS [8] = '{7'h13, 7'h33, 7'h03, 7'h23,
                                             7'h63, 7'h37, 7'h6F, 7'h67};

    typedef struct packed {
        int   total;
        logic mem;
        logic store;
        logic rw;
        int   wb;
        int   pcsrc;
        int   imm;
        int   alub;
    } exp_t;

    // Reference: what one instruction must look like, from its class alone.
    function automatic exp_t model(input logic [6:0] op, input logic bt,
                                   input int fw, input int mw);
        exp_t m;
        logic wb_phase;
        m = '0;
        wb_phase = 1'b0;
        case (op)
            7'h33: begin m.rw = 1; m.wb = 0; m.imm = 0; m.alub = 0; wb_phase = 1; end
            7'h13: begin m.rw = 1; m.wb = 0; m.imm = 0; m.alub = 1; wb_phase = 1; end
            7'h03: begin m.mem = 1; m.rw = 1; m.wb = 1; m.imm = 0; m.alub = 1; wb_phase = 1; end
            7'h23: begin m.mem = 1; m.store = 1; m.imm = 1; m.alub = 1; end
            7'h63: begin m.imm = 2; m.alub = 0; m.pcsrc = bt ? 1 : 0; end
            7'h37: begin m.rw = 1; m.wb = 3; m.imm = 3; m.alub = 1; end
            7'h6F: begin m.rw = 1; m.wb = 2; m.pcsrc = 1; m.imm = 4; m.alub = 1; end
            7'h67: begin m.rw = 1; m.wb = 2; m.pcsrc = 2; m.imm = 0; m.alub = 1; end
            default: ;
        endcase
        // fetch (fw waits + 1) + decode + exec + optional mem + optional wb
        m.total = (fw + 1) + 2 + (m.mem ? mw + 1 : 0) + (wb_phase ? 1 : 0);
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; fw/mw are memory wait cycles.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic bt, input int fw, input int mw);
        exp_t m;
        int waited = 0;
        int n_ir = 0, n_pc = 0, n_rw = 0, n_req = 0, n_src = 0, n_we = 0;
        int ir_at = -1, pc_at = -1, rw_at = -1;
        int pcsrc_seen = -1, wb_seen = -1, imm_seen = -1, alub_seen = -1;
        int fetch_imm = -1;
        m = model(op, bt, fw, mw);
        opcode = op;
        branch_taken = bt;
        for (int c = 0; c < m.total; c++) begin
            @(negedge clk);
            if (mem_req) mem_ready = (waited == (mem_src ? mw : fw));
            else         mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (c == 0) fetch_imm = int'(imm_sel);
            if (ir_write) begin n_ir++; ir_at = c; end
            if (pc_write) begin
                n_pc++; pc_at = c;
                pcsrc_seen = int'(pc_src); imm_seen = int'(imm_sel); alub_seen = int'(alu_src_b);
            end
            if (reg_write) begin n_rw++; rw_at = c; wb_seen = int'(wb_sel); end
            if (mem_req) begin
                n_req++;
                if (mem_src) n_src++;
                if (mem_we) n_we++;
                if (mem_ready) waited = 0; else waited++;
            end
        end
        @(posedge clk);
        #1;
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL %s end_state: got %0d want 1", name, state); end
        n_tests++; if (n_ir !== 1) begin n_fail++; $display("FAIL %s ir_write_count: got %0d want 1", name, n_ir); end
        n_tests++; if (ir_at !== fw) begin n_fail++; $display("FAIL %s ir_write_cycle: got %0d want %0d", name, ir_at, fw); end
        n_tests++; if (n_pc !== 1) begin n_fail++; $display("FAIL %s pc_write_count: got %0d want 1", name, n_pc); end
        n_tests++; if (pc_at !== m.total - 1) begin n_fail++; $display("FAIL %s pc_write_cycle: got %0d want %0d", name, pc_at, m.total - 1); end
        n_tests++; if (pcsrc_seen !== m.pcsrc) begin n_fail++; $display("FAIL %s pc_src: got %0d want %0d", name, pcsrc_seen, m.pcsrc); end
        n_tests++; if (imm_seen !== m.imm) begin n_fail++; $display("FAIL %s imm_sel: got %0d want %0d", name, imm_seen, m.imm); end
        n_tests++; if (alub_seen !== m.alub) begin n_fail++; $display("FAIL %s alu_src_b: got %0d want %0d", name, alub_seen, m.alub); end
        n_tests++; if (fetch_imm !== 0) begin n_fail++; $display("FAIL %s imm_sel_in_fetch: got %0d want 0", name, fetch_imm); end
        n_tests++; if (n_rw !== int'(m.rw)) begin n_fail++; $display("FAIL %s reg_write_count: got %0d want %0d", name, n_rw, m.rw); end
        if (m.rw) begin
            n_tests++; if (rw_at !== m.total - 1) begin n_fail++; $display("FAIL %s reg_write_cycle: got %0d want %0d", name, rw_at, m.total - 1); end
            n_tests++; if (wb_seen !== m.wb) begin n_fail++; $display("FAIL %s wb_sel: got %0d want %0d", name, wb_seen, m.wb); end
        end
        n_tests++; if (n_req !== fw + 1 + (m.mem ? mw + 1 : 0)) begin n_fail++; $display("FAIL %s mem_req_cycles: got %0d want %0d", name, n_req, fw + 1 + (m.mem ? mw + 1 : 0)); end
        n_tests++; if (n_src !== (m.mem ? mw + 1 : 0)) begin n_fail++; $display("FAIL %s mem_src_cycles: got %0d want %0d", name, n_src, (m.mem ? mw + 1 : 0)); end
        n_tests++; if (n_we !== (m.store ? mw + 1 : 0)) begin n_fail++; $display("FAIL %s mem_we_cycles: got %0d want %0d", name, n_we, (m.store ? mw + 1 : 0)); end
        n_tests++; if ({illegal, bus_err} !== 2'b00) begin n_fail++; $display("FAIL %s sticky_flags: got %b want 00", name, {illegal, bus_err}); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_we, mem_src, ir_write, pc_write, pc_src, reg_write, wb_sel,
             alu_src_b, imm_sel, illegal, bus_err, state} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero", {mem_req, mem_we, mem_src, ir_write,
                     pc_write, pc_src, reg_write, wb_sel, alu_src_b, imm_sel, illegal, bus_err, state});
        end
        rst_n = 1'b1;
        #1;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_idle: got %0d want 0", state); end
        @(posedge clk);
        #1;
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL idle_to_fetch: got %0d want 1", state); end
    endtask

    task automatic test_directed();
        run_instr("addi", 7'h13, 1'b0, 0, 0);
        run_instr("lw_wait3", 7'h03, 1'b0, 0, 3);
        run_instr("beq_taken", 7'h63, 1'b1, 0, 0);
        run_instr("beq_not_taken", 7'h63, 1'b0, 0, 0);
        run_instr("sw", 7'h23, 1'b0, 1, 2);
        run_instr("jal", 7'h6F, 1'b0, 0, 0);
        run_instr("jalr", 7'h67, 1'b1, 0, 0);
        run_instr("lui", 7'h37, 1'b0, 0, 0);
        run_instr("add", 7'h33, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        int stray = 0;
        opcode = 7'h7F;
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL illegal_decode: got %0d want 2", state); end
        @(negedge clk);
        #1;
        n_tests++; if (state !== 3'd6) begin n_fail++; $display("FAIL illegal_halt: got %0d want 6", state); end
        n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", illegal); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            opcode = 7'($urandom);
            #1;
            if (mem_req || ir_write || pc_write || reg_write || state != 3'd6 || !illegal) stray++;
        end
        n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL halt_absorbing: got %0d active cycles want 0", stray); end
        do_reset();
        n_tests++; if ({illegal, state} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL illegal_cleared: got %b want 0001", {illegal, state}); end
    endtask

    task automatic test_timeout();
        int n_req = 0;
        int n_src = 0;
        bit halted = 0;
        opcode = 7'h13;
        for (int c = 0; c < 40 && !halted; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (state == 3'd6) halted = 1;
            else if (mem_req) n_req++;
        end
        n_tests++; if (!halted) begin n_fail++; $display("FAIL fetch_timeout_halt: got no halt within 40 cycles want halt"); end
        n_tests++; if (n_req !== 16) begin n_fail++; $display("FAIL fetch_timeout_cycles: got %0d want 16", n_req); end
        n_tests++; if ({bus_err, illegal} !== 2'b10) begin n_fail++; $display("FAIL fetch_bus_err: got %b want 10", {bus_err, illegal}); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_tests++; if ({mem_req, state} !== {1'b0, 3'd6}) begin n_fail++; $display("FAIL bus_err_halt_hold: got %b want 0110", {mem_req, state}); end
        do_reset();
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL bus_err_cleared: got %b want 0", bus_err); end
        run_instr("fetch_ready_on_16", 7'h13, 1'b0, 15, 0);
        run_instr("mem_ready_on_16", 7'h03, 1'b0, 0, 15);

        opcode = 7'h23;
        halted = 0;
        for (int c = 0; c < 40 && !halted; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req && !mem_src) mem_ready = 1'b1;
            #1;
            if (state == 3'd6) halted = 1;
            else if (mem_req && mem_src) n_src++;
        end
        n_tests++; if (!halted) begin n_fail++; $display("FAIL mem_timeout_halt: got no halt within 40 cycles want halt"); end
        n_tests++; if (n_src !== 16) begin n_fail++; $display("FAIL mem_timeout_cycles: got %0d want 16", n_src); end
        n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL mem_bus_err: got %b want 1", bus_err); end
        do_reset();
    endtask

    task automatic test_reset_mid_mem();
        opcode = 7'h03;
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++; if ({mem_req, mem_src, state} !== {2'b11, 3'd4}) begin n_fail++; $display("FAIL mid_mem_setup: got %b want 11100", {mem_req, mem_src, state}); end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if ({mem_req, state} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL async_reset_drop: got %b want 0000", {mem_req, state}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if ({mem_req, state} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL restart_fetch: got %b want 1001", {mem_req, state}); end
        run_instr("after_reset", 7'h03, 1'b0, 1, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr("random", LEGAL_OPS[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
